// File: rtl/washer_dispense_ctrl_pkg.sv
// rtl/washer_dispense_ctrl_pkg.sv - shared state encoding and constants for the washer dispenser
package washer_dispense_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOWN = 2'd1,
        ST_UP   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic SERVO_UP   = 1'b0;
    localparam logic SERVO_DOWN = 1'b1;

    localparam int DEFAULT_DOWN_FRAMES = 25;
    localparam int DEFAULT_UP_FRAMES   = 25;
    localparam int DWELL_W             = 8;

endpackage

// File: rtl/washer_dwell_timer.sv
// rtl/washer_dwell_timer.sv - frame-tick down-counter timing one servo dwell phase
module washer_dwell_timer
    import washer_dispense_ctrl_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               tick,
    output logic               expire
);

    logic [DWELL_W-1:0] r_count;

    // A load takes priority, so a tick arriving in the load cycle is not counted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - DWELL_W'(1);
        end
    end

    assign expire = tick && (r_count == DWELL_W'(1));

endmodule

// File: rtl/washer_dispense_ctrl.sv
// rtl/washer_dispense_ctrl.sv - sequences servo down/up strokes to dispense a requested washer count
module washer_dispense_ctrl
    import washer_dispense_ctrl_pkg::*;
#(
    parameter int DOWN_FRAMES = DEFAULT_DOWN_FRAMES,
    parameter int UP_FRAMES   = DEFAULT_UP_FRAMES,
    parameter int CNT_W       = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             frameTick,
    input  logic             req,
    input  logic [CNT_W-1:0] reqCount,
    input  logic             abort,
    output logic             controlServo,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] dispensed
);

    localparam logic [DWELL_W-1:0] DOWN_LOAD = DWELL_W'(DOWN_FRAMES);
    localparam logic [DWELL_W-1:0] UP_LOAD   = DWELL_W'(UP_FRAMES);

    state_t             r_state;
    state_t             w_nxt_state;
    logic               r_servo;
    logic               r_busy;
    logic               r_done;
    logic               r_aborted;
    logic [CNT_W-1:0]   r_dispensed;
    logic [CNT_W-1:0]   r_remaining;
    logic               w_nxt_aborted;
    logic [CNT_W-1:0]   w_nxt_dispensed;
    logic [CNT_W-1:0]   w_nxt_remaining;
    logic               w_load;
    logic [DWELL_W-1:0] w_load_val;
    logic               w_expire;

    washer_dwell_timer u_dwell (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (w_load),
        .load_val (w_load_val),
        .tick     (frameTick),
        .expire   (w_expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_aborted   = r_aborted;
        w_nxt_dispensed = r_dispensed;
        w_nxt_remaining = r_remaining;
        w_load          = 1'b0;
        w_load_val      = DOWN_LOAD;

        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_nxt_dispensed = '0;
                    w_nxt_aborted   = 1'b0;
                    if (reqCount != '0) begin
                        w_nxt_remaining = reqCount;
                        w_load          = 1'b1;
                        w_load_val      = DOWN_LOAD;
                        w_nxt_state     = ST_DOWN;
                    end else begin
                        w_nxt_state     = ST_DONE;
                    end
                end
            end
            ST_DOWN: begin
                // Abort beats a coincident terminal tick: the stroke in progress is never counted.
                if (abort) begin
                    w_nxt_remaining = '0;
                    w_nxt_aborted   = 1'b1;
                    w_load          = 1'b1;
                    w_load_val      = UP_LOAD;
                    w_nxt_state     = ST_UP;
                end else if (w_expire) begin
                    w_nxt_dispensed = r_dispensed + CNT_W'(1);
                    w_nxt_remaining = r_remaining - CNT_W'(1);
                    w_load          = 1'b1;
                    w_load_val      = UP_LOAD;
                    w_nxt_state     = ST_UP;
                end
            end
            ST_UP: begin
                // The UP dwell always runs out so the servo is settled before the job ends.
                if (abort) begin
                    w_nxt_remaining = '0;
                    w_nxt_aborted   = 1'b1;
                end
                if (w_expire) begin
                    if (!abort && (r_remaining != '0)) begin
                        w_load      = 1'b1;
                        w_load_val  = DOWN_LOAD;
                        w_nxt_state = ST_DOWN;
                    end else begin
                        w_nxt_state = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_servo     <= SERVO_UP;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_dispensed <= '0;
            r_remaining <= '0;
        end else begin
            r_servo     <= (w_nxt_state == ST_DOWN) ? SERVO_DOWN : SERVO_UP;
            r_busy      <= (w_nxt_state == ST_DOWN) || (w_nxt_state == ST_UP);
            r_done      <= (w_nxt_state == ST_DONE);
            r_aborted   <= w_nxt_aborted;
            r_dispensed <= w_nxt_dispensed;
            r_remaining <= w_nxt_remaining;
        end
    end

    assign controlServo = r_servo;
    assign busy         = r_busy;
    assign done         = r_done;
    assign aborted      = r_aborted;
    assign dispensed    = r_dispensed;

endmodule
